// File: rtl/disp_mem_if.sv
// Display-memory bus between the ping-pong sequencer and the two 1-bit banks.
interface disp_mem_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              wr_disp_mem_0;
    logic              wr_disp_mem_1;
    logic [ADDR_W-1:0] addr_disp_mem_0;
    logic [ADDR_W-1:0] addr_disp_mem_1;
    logic              d_in_disp_mem_0;
    logic              d_in_disp_mem_1;
    logic              d_o_disp_mem_0;
    logic              d_o_disp_mem_1;

    modport master (
        output wr_disp_mem_0, wr_disp_mem_1,
        output addr_disp_mem_0, addr_disp_mem_1,
        output d_in_disp_mem_0, d_in_disp_mem_1,
        input  d_o_disp_mem_0, d_o_disp_mem_1
    );

    modport slave (
        input  wr_disp_mem_0, wr_disp_mem_1,
        input  addr_disp_mem_0, addr_disp_mem_1,
        input  d_in_disp_mem_0, d_in_disp_mem_1,
        output d_o_disp_mem_0, d_o_disp_mem_1
    );
endinterface

// File: rtl/disp_mem_ctrl.sv
// Ping-pong sequencer for the Viterbi traceback display memories: writes one
// bank at descending addresses while reading the other ascending, which
// undoes the traceback bit reversal, and frames the decoded output stream.
module disp_mem_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       d_in_valid,
    input  logic       tb_bit_valid,
    input  logic       tb_bit,
    input  logic       flush,
    disp_mem_if.master mem,
    output logic       decoder_o,
    output logic       d_out_valid,
    output logic       process_en,
    output logic       wr_bank,
    output logic       err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]  wr_cnt, wr_cnt_n;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_n;
    logic [CNT_W-1:0]  rd_len, rd_len_n;
    logic [ADDR_W-1:0] rd_start, rd_start_n;
    logic              rd_active, rd_active_n;
    logic              wr_bank_n, err_n, process_en_n;
    logic              din_q;
    logic [RD_LAT-1:0] dly_vld, dly_bank;

    logic              wr0_q, wr1_q, din0_q, din1_q;
    logic [ADDR_W-1:0] addr0_q, addr1_q;
    logic              wr0_n, wr1_n, din0_n, din1_n;
    logic [ADDR_W-1:0] addr0_n, addr1_n;

    logic              rise, in_frame, do_wr, blk_full, swap, rd_last, pending;
    logic [CNT_W-1:0]  cnt_wr;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    // Decode of the current cycle's events
    assign rise     = d_in_valid & ~din_q;
    assign in_frame = (state == FILL) || (state == STREAM);
    assign do_wr    = in_frame & tb_bit_valid;
    assign cnt_wr   = wr_cnt + CNT_W'(do_wr);
    assign blk_full = do_wr && (wr_cnt == LAST_CNT);
    assign swap     = in_frame && (blk_full || (flush && (cnt_wr != '0)));
    assign rd_last  = rd_active && (rd_cnt == rd_len - CNT_W'(1));
    assign pending  = |dly_vld[RD_LAT-2:0];
    assign wr_addr  = ADDR_W'(DEPTH - 1) - wr_cnt[ADDR_W-1:0];
    assign rd_addr  = rd_start + rd_cnt[ADDR_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state, bank/counter bookkeeping and next memory-port values
    always_comb begin
        state_n     = state;
        wr_bank_n   = wr_bank;
        wr_cnt_n    = wr_cnt;
        rd_active_n = rd_active;
        rd_cnt_n    = rd_cnt;
        rd_start_n  = rd_start;
        rd_len_n    = rd_len;
        err_n       = err;
        wr0_n       = 1'b0;
        wr1_n       = 1'b0;
        din0_n      = 1'b0;
        din1_n      = 1'b0;
        addr0_n     = '0;
        addr1_n     = '0;

        if (rd_active) begin
            if (wr_bank) addr0_n = rd_addr;
            else         addr1_n = rd_addr;
            rd_cnt_n = rd_cnt + CNT_W'(1);
            if (rd_last) rd_active_n = 1'b0;
        end

        if (do_wr) begin
            wr_cnt_n = cnt_wr;
            if (wr_bank) begin
                wr1_n   = 1'b1;
                addr1_n = wr_addr;
                din1_n  = tb_bit;
            end else begin
                wr0_n   = 1'b1;
                addr0_n = wr_addr;
                din0_n  = tb_bit;
            end
        end

        // A full block and a partial flush share one formula: start = DEPTH - count
        if (swap) begin
            wr_bank_n   = ~wr_bank;
            wr_cnt_n    = '0;
            rd_active_n = 1'b1;
            rd_cnt_n    = '0;
            rd_start_n  = ADDR_W'(FULL_CNT - cnt_wr);
            rd_len_n    = cnt_wr;
            if (rd_active && !rd_last) err_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (rise) state_n = FILL;
            end
            FILL: begin
                if (flush) begin
                    state_n  = DRAIN;
                    wr_cnt_n = '0;
                end else if (blk_full) begin
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (flush) begin
                    state_n  = DRAIN;
                    wr_cnt_n = '0;
                end
            end
            DRAIN: begin
                if (rise || tb_bit_valid) err_n = 1'b1;
                if (!rd_active && !pending) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        process_en_n = (state_n != IDLE);
    end

    // Datapath registers, memory-port registers and read-latency delay line
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_active  <= 1'b0;
            rd_cnt     <= '0;
            rd_start   <= '0;
            rd_len     <= '0;
            err        <= 1'b0;
            process_en <= 1'b0;
            din_q      <= 1'b0;
            dly_vld    <= '0;
            dly_bank   <= '0;
            wr0_q      <= 1'b0;
            wr1_q      <= 1'b0;
            din0_q     <= 1'b0;
            din1_q     <= 1'b0;
            addr0_q    <= '0;
            addr1_q    <= '0;
        end else begin
            wr_bank    <= wr_bank_n;
            wr_cnt     <= wr_cnt_n;
            rd_active  <= rd_active_n;
            rd_cnt     <= rd_cnt_n;
            rd_start   <= rd_start_n;
            rd_len     <= rd_len_n;
            err        <= err_n;
            process_en <= process_en_n;
            din_q      <= d_in_valid;
            dly_vld    <= {dly_vld[RD_LAT-2:0], rd_active};
            dly_bank   <= {dly_bank[RD_LAT-2:0], ~wr_bank};
            wr0_q      <= wr0_n;
            wr1_q      <= wr1_n;
            din0_q     <= din0_n;
            din1_q     <= din1_n;
            addr0_q    <= addr0_n;
            addr1_q    <= addr1_n;
        end
    end

    assign mem.wr_disp_mem_0   = wr0_q;
    assign mem.wr_disp_mem_1   = wr1_q;
    assign mem.addr_disp_mem_0 = addr0_q;
    assign mem.addr_disp_mem_1 = addr1_q;
    assign mem.d_in_disp_mem_0 = din0_q;
    assign mem.d_in_disp_mem_1 = din1_q;

    // Memory output is already registered; select the bank the read was issued on
    assign d_out_valid = dly_vld[RD_LAT-1];
    assign decoder_o   = d_out_valid &
                         (dly_bank[RD_LAT-1] ? mem.d_o_disp_mem_1 : mem.d_o_disp_mem_0);

endmodule

// File: doc/disp_mem_ctrl.md
Name: disp_mem_ctrl

Overview:
Sequencer for the two single-port display memories (mem_disp, 2^ADDR_W x 1) at the output of the Viterbi traceback. It ping-pongs the banks: traceback bits are written into one bank at descending addresses while the previously filled bank is read at ascending addresses. Reading ascending undoes the traceback bit reversal. It also frames the decoded stream with d_out_valid/process_en and handles partial final blocks on flush.

Parameters:
ADDR_W, 5, display memory address width
DEPTH, 32, bits per block; must equal 2^ADDR_W
RD_LAT, 2, cycles from read-address output to decoder_o (1 memory + 1 output register)

Ports:
clk  in  1  clock
RST  in  1  synchronous active-high reset
d_in_valid  in  1  encoded input stream active; a rising edge starts a frame
tb_bit_valid  in  1  traceback bit strobe; at most 1 per cycle
tb_bit  in  1  decoded bit from traceback
flush  in  1  1-cycle pulse: end of frame, commit partial block
wr_disp_mem_0  out  1  write enable, bank 0
wr_disp_mem_1  out  1  write enable, bank 1
addr_disp_mem_0  out  ADDR_W  address, bank 0
addr_disp_mem_1  out  ADDR_W  address, bank 1
d_in_disp_mem_0  out  1  write data, bank 0
d_in_disp_mem_1  out  1  write data, bank 1
d_o_disp_mem_0  in  1  read data, bank 0 (registered, 1-cycle latency)
d_o_disp_mem_1  in  1  read data, bank 1
decoder_o  out  1  decoded output bit
d_out_valid  out  1  decoder_o qualifier
process_en  out  1  frame-active enable for the upstream pipeline
wr_bank  out  1  bank currently being written
err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0. state=IDLE; wr_bank=0; wr_cnt=0; no read active; RD_LAT delay line cleared. A mid-frame reset aborts the frame with no further writes or valid output.
- FSM states: IDLE, FILL, STREAM, DRAIN.
- IDLE -> FILL on a d_in_valid rising edge (d_in_valid=1, previous cycle 0); process_en=1 from the next cycle. tb_bit_valid and flush are ignored in IDLE.
- Write, in FILL/STREAM, when tb_bit_valid=1:
  - Next cycle: wr_disp_mem_<wr_bank>=1, addr=DEPTH-1-wr_cnt, d_in=tb_bit.
  - wr_cnt increments.
  - All memory-side outputs are registered.
- Block complete, on the write with wr_cnt=DEPTH-1:
  - wr_bank toggles and wr_cnt=0.
  - A read starts on the old bank with rd_start=0, rd_len=DEPTH.
  - FILL -> STREAM.
- Read: while active, each cycle drives addr_disp_mem_<~wr_bank>=rd_start+rd_cnt with wr=0, and rd_cnt increments. The read ends after rd_len issues.
- Output path:
  - Issue flag and bank id are delayed RD_LAT cycles.
  - decoder_o = selected d_o register.
  - d_out_valid = delayed issue flag.
  - The first bit is valid RD_LAT+1 cycles after the block-completing strobe.
- Idle addresses: any bank port not written or read in a cycle drives wr=0, addr=0, d_in=0.
- flush in FILL/STREAM:
  - If tb_bit_valid=1 in the same cycle, that bit is written and counted first.
  - If the resulting wr_cnt>0: bank swap with rd_start=DEPTH-wr_cnt, rd_len=wr_cnt; wr_cnt=0.
  - If wr_cnt=0: no swap.
  - Go to DRAIN.
- DRAIN -> IDLE once no read is active and the delay line is empty; process_en=0 in that same cycle.
- err (cleared only by RST) is set on:
  - a bank swap while a read is still active; the old read is abandoned and the new one starts;
  - a d_in_valid rising edge in DRAIN, which is otherwise ignored;
  - tb_bit_valid in DRAIN, where the bit is dropped.
- Counters: wr_cnt and rd_cnt are ADDR_W+1 bits wide. Addresses wrap modulo DEPTH; compliant traffic never wraps.

Test Plan:
- Reset then 32 consecutive strobes, tb_bit=bit i for i=0..31 -> bank 0 writes addr 31..0, wr_bank=1 after the 32nd, then 32 cycles of d_out_valid with decoder_o = bits in addr order 0..31 (reversal), first valid 3 cycles after the 32nd strobe.
- 96 continuous strobes -> banks alternate 0,1,0; 96 contiguous d_out_valid cycles with no gaps; err=0.
- 40 strobes then flush -> after block 1, read of bank 1 at addr 24..31 (8 bits); d_out_valid totals 40; process_en falls 2 cycles after the last read issue.
- flush coincident with the 32nd strobe -> exactly one swap, full 32-bit read, DRAIN then IDLE, err=0.
- Strobe burst of 32 that completes while a partial read is still running (forced via flush-less swap timing) -> err=1 and the new read starts at addr 0.
- RST asserted mid-STREAM -> next cycle all outputs 0, wr_bank=0; a subsequent d_in_valid edge restarts cleanly from bank 0.
